dsp_mac_pipe: RTL

- Parametrised, signed successor of the team's 18x18 DSP slice: pre-adder, multiplier, X/Z post-adder muxes and accumulator P register.
- Adds generic widths, configurable input pipeline depth, a valid bit that travels with each sample, per-sample OPMODE, saturation with overflow flag, and pattern detect.
- Used as the MAC element in FIR/correlator datapaths, cascaded through PCIN/PCOUT.

---
 rtl/dsp_mac_pipe.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dsp_mac_pipe.sv
// Parametrised signed DSP MAC slice: pre-adder, multiplier, X/Z post-adder and a
// saturating P accumulator with pattern detect. A valid bit travels with each sample.
module dsp_mac_pipe #(
   parameter int             A_W     = 18,
   parameter int             B_W     = 18,
   parameter int             P_W     = 48,
   parameter int             IREG    = 1,
   parameter int             MREG    = 1,
   parameter bit             SAT_EN  = 1'b1,
   parameter logic [P_W-1:0] PATTERN = '0,
   parameter logic [P_W-1:0] MASK    = '1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CE,
   input  logic                 in_valid,
   input  logic [7:0]           OPMODE,
   input  logic [A_W-1:0]       A,
   input  logic [B_W-1:0]       B,
   input  logic [B_W-1:0]       D,
   input  logic [P_W-1:0]       C,
   input  logic [P_W-1:0]       PCIN,
   output logic                 out_valid,
   output logic [P_W-1:0]       P,
   output logic [P_W-1:0]       PCOUT,
   output logic [A_W+B_W:0]     M,
   output logic                 OVERFLOW,
   output logic                 PATTERNDETECT
);

   localparam int M_W = A_W + B_W + 1;
   localparam int S_W = P_W + 1;
   localparam logic [P_W-1:0] P_MAX = {1'b0, {(P_W-1){1'b1}}};
   localparam logic [P_W-1:0] P_MIN = {1'b1, {(P_W-1){1'b0}}};
   // Reset loads P with zero, so the detect flag starts as the compare of zero.
   localparam logic PD_RST = ((PATTERN & ~MASK) == '0);

   typedef struct packed {
      logic           valid;
      logic [7:0]     mode;
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      logic [B_W-1:0] d;
      logic [P_W-1:0] c;
   } in_smp_t;

   typedef struct packed {
      logic           valid;
      logic           post_sub;
      logic           cin;
      logic [1:0]     z_sel;
      logic [1:0]     x_sel;
      logic [A_W-1:0] a;
      logic [P_W-1:0] c;
   } post_smp_t;

   in_smp_t   s_in;
   in_smp_t   s_i;
   post_smp_t p_in;
   post_smp_t p_m;

   logic [B_W:0]     b_ext;
   logic [B_W:0]     d_ext;
   logic [B_W:0]     b_eff;
   logic [M_W-1:0]   m_prod;
   logic [M_W-1:0]   m_m;
   logic [S_W-1:0]   x_mux;
   logic [S_W-1:0]   z_mux;
   logic [S_W-1:0]   cin_ext;
   logic [S_W-1:0]   s_sum;
   logic             ovf;
   logic [P_W-1:0]   p_next;
   logic             pd_next;

   assign s_in = '{valid: in_valid, mode: OPMODE, a: A, b: B, d: D, c: C};

   // Input pipeline: the whole sample, including its mode and valid bit, moves together.
   generate
      if (IREG == 0) begin : g_no_ireg
         assign s_i = s_in;
      end else begin : g_ireg
         in_smp_t pipe_q [IREG];

         always_ff @(posedge CLK) begin
            // NOTE: sequential state uses non-blocking assignments so every stage
            // samples the pre-edge value of its predecessor.
            if (RST) begin
               for (int i = 0; i < IREG; i++) pipe_q[i] <= '0;
            end else if (CE) begin
               pipe_q[0] <= s_in;
               for (int i = 1; i < IREG; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign s_i = pipe_q[IREG-1];
      end
   endgenerate

   assign b_ext = {s_i.b[B_W-1], s_i.b};
   assign d_ext = {s_i.d[B_W-1], s_i.d};

   always_comb begin
      // NOTE: default assigned first so no path leaves b_eff unassigned (no latch).
      b_eff = b_ext;
      if (s_i.mode[4]) begin
         b_eff = s_i.mode[6] ? (d_ext - b_ext) : (d_ext + b_ext);
      end
   end

   assign m_prod = $signed(s_i.a) * $signed(b_eff);

   assign p_in = '{valid:    s_i.valid,
                   post_sub: s_i.mode[7],
                   cin:      s_i.mode[5],
                   z_sel:    s_i.mode[3:2],
                   x_sel:    s_i.mode[1:0],
                   a:        s_i.a,
                   c:        s_i.c};

   // The M register loads on every enabled cycle, valid or not.
   generate
      if (MREG == 0) begin : g_no_mreg
         assign p_m = p_in;
         assign m_m = m_prod;
      end else begin : g_mreg
         post_smp_t p_q;
         logic [M_W-1:0] m_q;

         always_ff @(posedge CLK) begin
            if (RST) begin
               p_q <= '0;
               m_q <= '0;
            end else if (CE) begin
               p_q <= p_in;
               m_q <= m_prod;
            end
         end

         assign p_m = p_q;
         assign m_m = m_q;
      end
   endgenerate

   assign M = m_m;

   // Post-adder works one bit wider than P so overflow is visible in the top two bits.
   always_comb begin
      x_mux = '0;
      case (p_m.x_sel)
         2'd1:    x_mux = {{(S_W-M_W){m_m[M_W-1]}}, m_m};
         2'd2:    x_mux = {P[P_W-1], P};
         2'd3:    x_mux = {{(S_W-A_W){p_m.a[A_W-1]}}, p_m.a};
         default: x_mux = '0;
      endcase

      z_mux = '0;
      case (p_m.z_sel)
         2'd1:    z_mux = {PCIN[P_W-1], PCIN};
         2'd2:    z_mux = {P[P_W-1], P};
         2'd3:    z_mux = {p_m.c[P_W-1], p_m.c};
         default: z_mux = '0;
      endcase

      cin_ext = {{(S_W-1){1'b0}}, p_m.cin};
      s_sum   = p_m.post_sub ? (z_mux - (x_mux + cin_ext)) : (z_mux + x_mux + cin_ext);
   end

   assign ovf = s_sum[S_W-1] ^ s_sum[S_W-2];

   always_comb begin
      p_next = s_sum[P_W-1:0];
      if (SAT_EN && ovf) begin
         p_next = s_sum[S_W-1] ? P_MIN : P_MAX;
      end
   end

   assign pd_next = ((p_next ^ PATTERN) & ~MASK) == '0;

   // P and its flags move only for a valid final-stage sample; bubbles leave P intact.
   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid     <= 1'b0;
         P             <= '0;
         OVERFLOW      <= 1'b0;
         PATTERNDETECT <= PD_RST;
      end else if (CE) begin
         out_valid <= p_m.valid;
         if (p_m.valid) begin
            P             <= p_next;
            OVERFLOW      <= ovf;
            PATTERNDETECT <= pd_next;
         end
      end
   end

   assign PCOUT = P;

endmodule
